scrambler_lfsr_ctrl: RTL and testbench

Sequencer that owns the scrambler's 285-bit primary LFSR through the LFSR's register-style load port and its enable input. It accepts a full-width seed over a valid/ready handshake, serialises it into nine 32-bit word writes at LFSR addresses 0x081..0x089, then runs the LFSR for fixed-length blocks on request. It sits between the scrambler top-level control and the LFSR instance. It is the only driver of the LFSR's `enable`, `write`, `addr` and `lfsrdin` inputs.

---
 rtl/scrambler_pkg.sv | 20 ++
 rtl/scrambler_lfsr_ctrl_seed_word_mux.sv | 41 ++++
 rtl/scrambler_lfsr_ctrl.sv | 138 +++++++++++++
 tb/tb_scrambler_lfsr_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// Shared types and constants for the scrambler LFSR control path.
// Holds the sequencer state encoding and the LFSR load-port geometry.
package scrambler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } lfsr_ctrl_state_t;

    localparam logic [11:0] LFSR_BASE_ADDR = 12'h081;
    localparam int          LFSR_WORD_W    = 32;
    localparam int          LFSR_POLY_W    = 285;

    function automatic int words_for_width(input int width);
        return (width + LFSR_WORD_W - 1) / LFSR_WORD_W;
    endfunction

endpackage

// File: rtl/scrambler_lfsr_ctrl_seed_word_mux.sv
// Selects one 32-bit load word from the seed holding register by word index.
// Bit positions beyond the LFSR width read as zero, so the top word is zero-filled.
module seed_word_mux
    import scrambler_pkg::*;
#(
    parameter int POLY_WIDTH = LFSR_POLY_W,
    parameter int NUM_WORDS  = words_for_width(LFSR_POLY_W),
    parameter int IDX_W      = 4
) (
    input  logic [POLY_WIDTH-1:0]  hold,
    input  logic [IDX_W-1:0]       idx,
    output logic [LFSR_WORD_W-1:0] word
);

    localparam int PAD_W = NUM_WORDS * LFSR_WORD_W;

    logic [PAD_W-1:0]       w_padded;
    logic [LFSR_WORD_W-1:0] w_words [NUM_WORDS];

    for (genvar gi = 0; gi < PAD_W; gi++) begin : g_pad
        if (gi < POLY_WIDTH) begin : g_bit
            assign w_padded[gi] = hold[gi];
        end else begin : g_zero
            assign w_padded[gi] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        assign w_words[gi] = w_padded[gi*LFSR_WORD_W +: LFSR_WORD_W];
    end

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (idx == k[IDX_W-1:0]) begin
                word = w_words[k];
            end
        end
    end

endmodule

// File: rtl/scrambler_lfsr_ctrl.sv
// Seed-load and block-run sequencer for the scrambler's primary LFSR.
// Serialises a full-width seed into word writes, then runs fixed-length enable blocks.
module scrambler_lfsr_ctrl
    import scrambler_pkg::*;
#(
    parameter int          POLY_WIDTH = LFSR_POLY_W,
    parameter int          NUM_WORDS  = words_for_width(LFSR_POLY_W),
    parameter logic [11:0] BASE_ADDR  = LFSR_BASE_ADDR,
    parameter int          BLOCK_LEN  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_valid,
    output logic                   seed_ready,
    input  logic [POLY_WIDTH-1:0]  seed,
    input  logic                   blk_req,
    output logic                   blk_ack,
    output logic                   blk_done,
    output logic                   seeded,
    output logic                   busy,
    output logic                   lfsr_enable,
    output logic                   lfsr_write,
    output logic [11:0]            lfsr_addr,
    output logic [LFSR_WORD_W-1:0] lfsr_din
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    lfsr_ctrl_state_t r_state, w_state_next;
    logic [IDX_W-1:0]      r_idx, w_idx_next;
    logic [7:0]            r_cnt, w_cnt_next;
    logic [POLY_WIDTH-1:0] r_hold, w_hold_next;
    logic                  r_seeded, w_seeded_next;

    logic                   r_lfsr_write;
    logic                   r_lfsr_enable;
    logic [11:0]            r_lfsr_addr;
    logic [LFSR_WORD_W-1:0] r_lfsr_din;
    logic                   r_busy;
    logic                   r_blk_done;

    logic                   w_write_next;
    logic [LFSR_WORD_W-1:0] w_mux_word;

    seed_word_mux #(
        .POLY_WIDTH (POLY_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .IDX_W      (IDX_W)
    ) u_seed_word_mux (
        .hold (w_hold_next),
        .idx  (w_idx_next),
        .word (w_mux_word)
    );

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_cnt_next    = r_cnt;
        w_hold_next   = r_hold;
        w_seeded_next = r_seeded;
        case (r_state)
            IDLE: begin
                // A seed offer takes priority; a pending block request waits for the next IDLE cycle.
                if (seed_valid) begin
                    w_hold_next  = seed;
                    w_idx_next   = '0;
                    w_state_next = LOAD;
                end else if (blk_req && r_seeded) begin
                    w_cnt_next   = '0;
                    w_state_next = RUN;
                end
            end
            LOAD: begin
                if (r_idx == IDX_W'(NUM_WORDS - 1)) begin
                    w_seeded_next = 1'b1;
                    w_state_next  = IDLE;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == 8'(BLOCK_LEN - 1)) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_write_next = (w_state_next == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_seeded      <= 1'b0;
            r_lfsr_write  <= 1'b0;
            r_lfsr_enable <= 1'b0;
            r_lfsr_addr   <= '0;
            r_lfsr_din    <= '0;
            r_busy        <= 1'b0;
            r_blk_done    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_cnt         <= w_cnt_next;
            r_hold        <= w_hold_next;
            r_seeded      <= w_seeded_next;
            // Output registers track the state being entered, so they line up with that state's cycles.
            r_lfsr_write  <= w_write_next;
            r_lfsr_enable <= (w_state_next == RUN);
            r_lfsr_addr   <= w_write_next ? (BASE_ADDR + 12'(w_idx_next)) : 12'h000;
            r_lfsr_din    <= w_write_next ? w_mux_word : '0;
            r_busy        <= (w_state_next != IDLE);
            r_blk_done    <= (w_state_next == DONE);
        end
    end

    assign seed_ready  = (r_state == IDLE) && !rst;
    assign blk_ack     = (r_state == IDLE) && !rst && !seed_valid && blk_req && r_seeded;
    assign blk_done    = r_blk_done;
    assign seeded      = r_seeded;
    assign busy        = r_busy;
    assign lfsr_enable = r_lfsr_enable;
    assign lfsr_write  = r_lfsr_write;
    assign lfsr_addr   = r_lfsr_addr;
    assign lfsr_din    = r_lfsr_din;

endmodule

// File: tb/tb_scrambler_lfsr_ctrl.sv
// Self-checking bench for scrambler_lfsr_ctrl with a behavioural LFSR fed by the DUT's load/enable port.
module tb_scrambler_lfsr_ctrl;

    localparam int BLEN  = 16;
    localparam int POLYW = 285;

    logic             clk = 1'b0;
    logic             rst;
    logic             seed_valid;
    logic             seed_ready;
    logic [POLYW-1:0] seed;
    logic             blk_req;
    logic             blk_ack;
    logic             blk_done;
    logic             seeded;
    logic             busy;
    logic             lfsr_enable;
    logic             lfsr_write;
    logic [11:0]      lfsr_addr;
    logic [31:0]      lfsr_din;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [POLYW-1:0] m_lfsr = '0;
    logic [POLYW-1:0] exp_lfsr;

    scrambler_lfsr_ctrl #(
        .POLY_WIDTH (POLYW),
        .NUM_WORDS  (9),
        .BASE_ADDR  (12'h081),
        .BLOCK_LEN  (BLEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seed_valid  (seed_valid),
        .seed_ready  (seed_ready),
        .seed        (seed),
        .blk_req     (blk_req),
        .blk_ack     (blk_ack),
        .blk_done    (blk_done),
        .seeded      (seeded),
        .busy        (busy),
        .lfsr_enable (lfsr_enable),
        .lfsr_write  (lfsr_write),
        .lfsr_addr   (lfsr_addr),
        .lfsr_din    (lfsr_din)
    );

    always #5 clk = ~clk;

    // Arbitrary feedback polynomial; only the step count matters to the checks.
    function automatic logic [POLYW-1:0] adv(input logic [POLYW-1:0] s, input int n);
        logic [POLYW-1:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            v = {v[POLYW-2:0], v[284] ^ v[279] ^ v[197] ^ v[3]};
        end
        return v;
    endfunction

    function automatic logic [POLYW-1:0] rand_seed();
        logic [287:0] p;
        for (int k = 0; k < 9; k++) p[32*k +: 32] = $urandom;
        return p[POLYW-1:0];
    endfunction

    // Stand-in for the LFSR instance: word writes land at their slice, enables advance 11 steps.
    always @(posedge clk) begin
        if (lfsr_write) begin
            int k;
            k = int'(lfsr_addr) - 'h081;
            if (k >= 0 && k < 9) begin
                for (int b = 0; b < 32; b++) begin
                    if (32*k + b < POLYW) m_lfsr[32*k + b] <= lfsr_din[b];
                end
            end
        end else if (lfsr_enable) begin
            m_lfsr <= adv(m_lfsr, 11);
        end
        if (blk_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_seed(input logic [POLYW-1:0] s, input logic exp_ack_after);
        logic [287:0] pad;
        pad = {3'b000, s};
        @(negedge clk);
        seed = s;
        seed_valid = 1'b1;
        #1;
        chk("ready_at_T", seed_ready, 1'b1);
        chk("no_ack_at_T", blk_ack, 1'b0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            seed_valid = 1'b0;
            seed = rand_seed();
            #1;
            chk("ld_write", lfsr_write, 1'b1);
            chk("ld_addr", lfsr_addr, 12'h081 + 12'(k));
            chk("ld_din", lfsr_din, pad[32*k +: 32]);
            chk("ld_no_enable", lfsr_enable, 1'b0);
            chk("ld_busy", busy, 1'b1);
            chk("ld_not_ready", seed_ready, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("ready_T10", seed_ready, 1'b1);
        chk("seeded_T10", seeded, 1'b1);
        chk("idle_write", lfsr_write, 1'b0);
        chk("idle_addr", lfsr_addr, 12'h000);
        chk("idle_din", lfsr_din, 32'h0);
        chk("idle_busy", busy, 1'b0);
        chk("ack_T10", blk_ack, exp_ack_after);
        chk("lfsr_loaded", m_lfsr, s);
        exp_lfsr = s;
    endtask

    // Entered at the negedge where an ack was just observed.
    task automatic run_block(input logic drop_req);
        for (int i = 1; i <= BLEN; i++) begin
            @(negedge clk);
            if (drop_req && i == 1) blk_req = 1'b0;
            #1;
            chk("run_enable", lfsr_enable, 1'b1);
            chk("run_no_write", lfsr_write, 1'b0);
            chk("run_busy", busy, 1'b1);
            chk("run_no_done", blk_done, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("done_pulse", blk_done, 1'b1);
        chk("done_no_enable", lfsr_enable, 1'b0);
        chk("done_busy", busy, 1'b1);
        chk("done_no_ack", blk_ack, 1'b0);
        exp_lfsr = adv(exp_lfsr, 11 * BLEN);
        chk("lfsr_state", m_lfsr, exp_lfsr);
        @(negedge clk);
        #1;
        chk("post_done_clear", blk_done, 1'b0);
        chk("post_done_idle", busy, 1'b0);
        chk("next_ack", blk_ack, blk_req);
    endtask

    initial begin
        logic [287:0]     dpad;
        logic [POLYW-1:0] s;
        int               done_before;

        rst = 1'b1;
        seed_valid = 1'b0;
        seed = '0;
        blk_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", seed_ready, 1'b0);
        chk("rst_seeded", seeded, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_write", lfsr_write, 1'b0);
        chk("rst_enable", lfsr_enable, 1'b0);
        chk("rst_done", blk_done, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", seed_ready, 1'b1);

        // Block request with no seed must never be acknowledged.
        blk_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("unseeded_ack", blk_ack, 1'b0);
            chk("unseeded_enable", lfsr_enable, 1'b0);
        end

        // Directed seed offered while the request is still pending: seed wins, ack at T+10.
        for (int k = 0; k < 8; k++) dpad[32*k +: 32] = 32'hA000_0000 + 32'(k);
        dpad[287:256] = 32'h1ABC_DEF0;
        load_seed(dpad[POLYW-1:0], 1'b1);

        // Two back-to-back blocks with the request held throughout, then released.
        run_block(1'b0);
        run_block(1'b1);

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            load_seed(rand_seed(), 1'b0);
            blk_req = 1'b1;
            #1;
            chk("rand_ack", blk_ack, 1'b1);
            run_block(1'b1);
        end

        // Reset during the 4th word write.
        @(negedge clk);
        seed = rand_seed();
        seed_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            seed_valid = 1'b0;
        end
        #1;
        chk("pre_rst_write", lfsr_write, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("ldrst_write", lfsr_write, 1'b0);
        chk("ldrst_addr", lfsr_addr, 12'h000);
        chk("ldrst_din", lfsr_din, 32'h0);
        chk("ldrst_busy", busy, 1'b0);
        chk("ldrst_seeded", seeded, 1'b0);
        chk("ldrst_ready", seed_ready, 1'b0);
        rst = 1'b0;
        blk_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("partial_no_ack", blk_ack, 1'b0);
        end
        blk_req = 1'b0;

        // Reset during the 7th enable cycle of a block.
        s = rand_seed();
        load_seed(s, 1'b0);
        blk_req = 1'b1;
        #1;
        chk("r6_ack", blk_ack, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            blk_req = 1'b0;
            #1;
            chk("r6_enable", lfsr_enable, 1'b1);
        end
        done_before = done_cnt;
        rst = 1'b1;
        #1;
        chk("runrst_enable", lfsr_enable, 1'b0);
        chk("runrst_busy", busy, 1'b0);
        chk("runrst_done", blk_done, 1'b0);
        chk("runrst_seeded", seeded, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("runrst_quiet", lfsr_enable | blk_done, 1'b0);
        end
        chk("runrst_no_done", done_cnt, done_before);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
